// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the core (master) and the PC sequencer (slave).
interface pc_sequencer_if;
    logic [31:0] PCCurrent;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Exception;
    logic        Halt;
    logic        Resume;
    logic [31:0] NextPC;
    logic        PCWrite;
    logic        IFFlush;
    logic [31:0] EPC;
    logic [1:0]  State;
    logic [31:0] FetchCount;
    modport master (
        output PCCurrent, Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Exception, Halt, Resume,
        input  NextPC, PCWrite, IFFlush, EPC, State, FetchCount
    );
    modport slave (
        input  PCCurrent, Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Exception, Halt, Resume,
        output NextPC, PCWrite, IFFlush, EPC, State, FetchCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: selects the next PC and load enable, tracks flush bubbles, halt and exception PC.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000080,
    parameter int          FLUSH_CYCLES = 1
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {BOOT, FETCH, FLUSH, HALT} state_t;
    localparam logic [1:0] FLUSH_LEN = 2'(FLUSH_CYCLES);
    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        redirect, seq_fetch;
    logic [31:0] target, pc_inc;
    assign pc_inc    = bus.PCCurrent + 32'd4;
    assign target    = bus.Exception ? EXC_VECTOR : bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
    assign bus.State = state;
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bus.NextPC  = bus.PCCurrent;
        bus.PCWrite = 1'b0;
        redirect    = 1'b0;
        seq_fetch   = 1'b0;
        case (state)
            BOOT: begin
                bus.NextPC  = RESET_VECTOR;
                bus.PCWrite = 1'b1;
                state_nxt   = FETCH;
            end
            FETCH: begin
                redirect  = bus.Exception | bus.BranchTaken | bus.Jump;
                seq_fetch = !redirect && !bus.Halt && !bus.Stall;
                if (!redirect && bus.Halt)
                    state_nxt = HALT;
            end
            FLUSH: begin
                redirect = bus.Exception;
                // A stalled flush keeps its bubble count so the squash lines up with the held fetch
                if (!redirect && !bus.Stall) begin
                    bus.NextPC  = pc_inc;
                    bus.PCWrite = 1'b1;
                    cnt_nxt     = cnt - 2'd1;
                    state_nxt   = (cnt == 2'd1) ? FETCH : FLUSH;
                end
            end
            HALT: begin
                redirect = bus.Exception;
                if (!redirect && bus.Resume)
                    state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
        if (seq_fetch) begin
            bus.NextPC  = pc_inc;
            bus.PCWrite = 1'b1;
        end
        if (redirect) begin
            bus.NextPC  = target;
            bus.PCWrite = 1'b1;
            state_nxt   = FLUSH;
            cnt_nxt     = FLUSH_LEN;
        end
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= BOOT;
            cnt            <= 2'd0;
            bus.IFFlush    <= 1'b0;
            bus.EPC        <= 32'd0;
            bus.FetchCount <= 32'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus.IFFlush <= (state_nxt == FLUSH);
            if (redirect && bus.Exception)
                bus.EPC <= bus.PCCurrent;
            if (seq_fetch)
                bus.FetchCount <= bus.FetchCount + 32'd1;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer with a two-cycle flush.
module tb_pc_sequencer;
    localparam int NPC = 0, PCW = 1, IFF = 2, EPCS = 3, ST = 4, FCNT = 5;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    pc_sequencer_if bus ();
    pc_sequencer #(
        .RESET_VECTOR(32'h00000000),
        .EXC_VECTOR  (32'h00000080),
        .FLUSH_CYCLES(2)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );
    always #5 Clk = ~Clk;
    typedef struct {
        int          sig;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;
    function automatic logic [31:0] observe(int sig);
        case (sig)
            NPC:     return bus.NextPC;
            PCW:     return {31'd0, bus.PCWrite};
            IFF:     return {31'd0, bus.IFFlush};
            EPCS:    return bus.EPC;
            ST:      return {30'd0, bus.State};
            default: return bus.FetchCount;
        endcase
    endfunction
    function automatic string tag(int sig);
        case (sig)
            NPC:     return "NextPC";
            PCW:     return "PCWrite";
            IFF:     return "IFFlush";
            EPCS:    return "EPC";
            ST:      return "State";
            default: return "FetchCount";
        endcase
    endfunction
    task automatic want(int sig, logic [31:0] val);
        sb.push_back('{sig, val});
    endtask
    task automatic chk(string step);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] obs;
            e = sb.pop_front();
            obs = observe(e.sig);
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s/%s: observed %h expected %h", step, tag(e.sig), obs, e.val);
            end
        end
    endtask
    task automatic comb(string step, logic [31:0] np, logic pw);
        #1;
        want(NPC, np);
        want(PCW, {31'd0, pw});
        chk(step);
    endtask
    task automatic regs(string step, logic [1:0] st, logic fl, logic [31:0] fc);
        want(ST, {30'd0, st});
        want(IFF, {31'd0, fl});
        want(FCNT, fc);
        chk(step);
    endtask
    task automatic clear();
        bus.Stall = 0; bus.BranchTaken = 0; bus.Jump = 0; bus.Exception = 0;
        bus.Halt = 0; bus.Resume = 0; bus.BranchTarget = 0; bus.JumpTarget = 0;
    endtask
    task automatic tick(logic [31:0] newpc);
        @(posedge Clk);
        #1;
        bus.PCCurrent = newpc;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        clear();
        bus.PCCurrent = 32'h12345678;
        #12;
        want(EPCS, 32'h0);
        regs("reset", 2'd0, 1'b0, 32'd0);
        comb("reset_comb", 32'h0, 1'b1);
        Reset = 1'b1;
        comb("boot", 32'h0, 1'b1);
        tick(32'h0);
        for (int i = 0; i < 5; i++) begin
            regs("run_regs", 2'd1, 1'b0, i);
            comb("run_comb", bus.PCCurrent + 32'd4, 1'b1);
            tick(bus.PCCurrent + 32'd4);
        end
        regs("run_end", 2'd1, 1'b0, 32'd5);
        bus.PCCurrent = 32'h20;
        bus.BranchTaken = 1; bus.BranchTarget = 32'h100;
        bus.Jump = 1; bus.JumpTarget = 32'h200;
        comb("branch", 32'h100, 1'b1);
        tick(32'h100);
        bus.Jump = 0; bus.BranchTarget = 32'h300;
        regs("br_flush1", 2'd2, 1'b1, 32'd5);
        comb("br_flush1", 32'h104, 1'b1);
        tick(32'h104);
        clear();
        regs("br_flush2", 2'd2, 1'b1, 32'd5);
        comb("br_flush2", 32'h108, 1'b1);
        tick(32'h108);
        regs("br_done", 2'd1, 1'b0, 32'd5);
        bus.PCCurrent = 32'h40;
        bus.Stall = 1;
        for (int i = 0; i < 3; i++) begin
            comb("stall", 32'h40, 1'b0);
            tick(32'h40);
            regs("stall_regs", 2'd1, 1'b0, 32'd5);
        end
        bus.Stall = 0;
        comb("unstall", 32'h44, 1'b1);
        tick(32'h44);
        regs("unstall", 2'd1, 1'b0, 32'd6);
        bus.PCCurrent = 32'h1C;
        bus.Exception = 1; bus.BranchTaken = 1; bus.BranchTarget = 32'h100;
        comb("exc", 32'h80, 1'b1);
        tick(32'h80);
        clear();
        want(EPCS, 32'h1C);
        regs("exc_regs", 2'd2, 1'b1, 32'd6);
        bus.Stall = 1;
        comb("flush_stall", 32'h80, 1'b0);
        tick(32'h80);
        regs("flush_stall", 2'd2, 1'b1, 32'd6);
        bus.Stall = 0;
        comb("flush_a", 32'h84, 1'b1);
        tick(32'h84);
        regs("flush_a", 2'd2, 1'b1, 32'd6);
        comb("flush_b", 32'h88, 1'b1);
        tick(32'h88);
        regs("flush_done", 2'd1, 1'b0, 32'd6);
        bus.PCCurrent = 32'h60;
        bus.Halt = 1;
        comb("halt", 32'h60, 1'b0);
        tick(32'h60);
        bus.Halt = 0;
        for (int i = 0; i < 3; i++) begin
            regs("halted", 2'd3, 1'b0, 32'd6);
            comb("halted", 32'h60, 1'b0);
            tick(32'h60);
        end
        bus.Resume = 1;
        comb("resume", 32'h60, 1'b0);
        tick(32'h60);
        bus.Resume = 0;
        regs("resumed", 2'd1, 1'b0, 32'd6);
        comb("resumed", 32'h64, 1'b1);
        tick(32'h64);
        regs("after_resume", 2'd1, 1'b0, 32'd7);
        bus.Halt = 1;
        tick(32'h64);
        bus.Halt = 0;
        bus.Exception = 1; bus.Resume = 1;
        comb("halt_exc", 32'h80, 1'b1);
        tick(32'h80);
        clear();
        want(EPCS, 32'h64);
        regs("halt_exc", 2'd2, 1'b1, 32'd7);
        Reset = 1'b0;
        #1;
        want(EPCS, 32'h0);
        regs("mid_flush_reset", 2'd0, 1'b0, 32'd0);
        comb("mid_flush_reset", 32'h0, 1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        comb("reboot", 32'h0, 1'b1);
        tick(32'h0);
        regs("reboot", 2'd1, 1'b0, 32'd0);
        tick(32'h4);
        regs("no_residual", 2'd1, 1'b0, 32'd1);
        bus.PCCurrent = 32'hFFFFFFFC;
        comb("wrap", 32'h0, 1'b1);
        tick(32'h0);
        regs("wrap", 2'd1, 1'b0, 32'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
